// File: rtl/fir_pkg.sv
// Shared widths and FSM encoding for the FIR go sequencer.
package fir_pkg;
    localparam int FIR_DATA_W = 8;
    localparam int FIR_OUT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fir_state_e;
endpackage

// File: rtl/sample_fifo.sv
// Power-of-2 sample FIFO with combinational head read and occupancy count.
module sample_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic              do_push, do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/fir_go_sequencer.sv
// Drains buffered samples into the FIR one at a time: go pulse, fixed-latency
// wait, capture y, then hold the result on a valid/ready output.
module fir_go_sequencer
    import fir_pkg::*;
#(
    parameter int DATA_W  = FIR_DATA_W,
    parameter int OUT_W   = FIR_OUT_W,
    parameter int FIR_LAT = 3,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DATA_W-1:0]       fir_in,
    output logic                    fir_go,
    input  logic [OUT_W-1:0]        fir_y,
    output logic [OUT_W-1:0]        m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    busy
);
    fir_state_e        state, state_nxt;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] head;
    logic              full, empty;
    logic              do_issue, do_capture, do_release;

    sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid && s_ready),
        .din   (s_data),
        .pop   (do_issue),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign s_ready = !full;
    assign busy    = (state != IDLE) || !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!empty) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (cnt == 4'd0) state_nxt = HOLD;
            HOLD:  if (m_ready) state_nxt = empty ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    // HOLD->ISSUE shares the IDLE issue path so results stream back-to-back.
    always_comb begin
        do_issue   = !empty && ((state == IDLE) || (state == HOLD && m_ready));
        do_capture = (state == WAIT) && (cnt == 4'd0);
        do_release = (state == HOLD) && m_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fir_go  <= 1'b0;
            fir_in  <= '0;
            cnt     <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            fir_go <= do_issue;
            if (do_issue) fir_in <= head;
            if (state == ISSUE)                 cnt <= 4'(FIR_LAT - 1);
            else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
            if (do_capture) begin
                m_data  <= fir_y;
                m_valid <= 1'b1;
            end else if (do_release) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_go_sequencer.sv
// Directed bench for fir_go_sequencer with a behavioural FIR (y = in*3, latency 3).
module tb_fir_go_sequencer;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  fir_in;
    logic        fir_go;
    logic [15:0] fir_y;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [2:0]  level;
    logic        busy;

    int total = 0;
    int bad   = 0;

    fir_go_sequencer #(.DATA_W(8), .OUT_W(16), .FIR_LAT(LAT), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .fir_in(fir_in), .fir_go(fir_go), .fir_y(fir_y), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIR model: y is valid only in the cycle before the edge LAT after go.
    logic [3:0]  fcnt;
    logic [15:0] fval;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt <= '0;
            fval <= '0;
        end else if (fir_go) begin
            fcnt <= 4'(LAT);
            fval <= 16'({8'h00, fir_in} * 16'd3);
        end else if (fcnt != 0) begin
            fcnt <= fcnt - 4'd1;
        end
    end
    assign fir_y = (fcnt == 4'd1) ? fval : 16'hDEAD;

    typedef struct {
        logic [7:0]  din;
        logic [15:0] res;
    } vec_t;

    logic [7:0]  push_q[$];
    logic [15:0] exp_q[$];
    int          go_cyc[$];
    int          res_cyc[$];
    bit          saw_full;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Push push_q while accepted, compare each accepted result against exp_q.
    task automatic run(input bit rand_rdy, input int budget);
        int cyc;
        bit pushed;
        cyc = 0;
        go_cyc.delete();
        res_cyc.delete();
        saw_full = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (push_q.size() != 0) begin
                s_valid = 1'b1;
                s_data  = push_q[0];
            end else begin
                s_valid = 1'b0;
            end
            pushed = s_valid && s_ready;
            if (m_valid && m_ready) begin
                check("result", m_data, exp_q.pop_front());
                res_cyc.push_back(cyc);
            end
            tick();
            cyc++;
            if (pushed) void'(push_q.pop_front());
            if (fir_go) go_cyc.push_back(cyc);
            if (!s_ready) saw_full = 1;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL run_timeout actual=%0d_left expected=0_left", exp_q.size());
            exp_q.delete();
            push_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t burst[5];
        vec_t wrap[10];
        bit   ok_a, ok_b, seen;

        burst[0] = '{8'h01, 16'h0003};
        burst[1] = '{8'h02, 16'h0006};
        burst[2] = '{8'h03, 16'h0009};
        burst[3] = '{8'h04, 16'h000C};
        burst[4] = '{8'h05, 16'h000F};
        wrap[0]  = '{8'h11, 16'h0033};
        wrap[1]  = '{8'h22, 16'h0066};
        wrap[2]  = '{8'h33, 16'h0099};
        wrap[3]  = '{8'h44, 16'h00CC};
        wrap[4]  = '{8'h55, 16'h00FF};
        wrap[5]  = '{8'h66, 16'h0132};
        wrap[6]  = '{8'h77, 16'h0165};
        wrap[7]  = '{8'h80, 16'h0180};
        wrap[8]  = '{8'h9A, 16'h01CE};
        wrap[9]  = '{8'hFF, 16'h02FD};

        // Reset state
        #2;
        check("rst_s_ready", s_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_fir_go", fir_go, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_fir_in", fir_in, 0);
        tick();
        rst = 1'b1;
        tick();

        // Single sample latency
        s_valid = 1'b1; s_data = 8'h07;
        tick();                                   // E0
        s_valid = 1'b0;
        check("single_lvl_e0", level, 1);
        check("single_go_e0", fir_go, 0);
        tick();                                   // E1
        check("single_go_e1", fir_go, 1);
        check("single_in_e1", fir_in, 8'h07);
        check("single_lvl_e1", level, 0);
        check("single_busy_e1", busy, 1);
        tick();                                   // E2
        check("single_go_e2", fir_go, 0);
        check("single_in_e2", fir_in, 8'h07);
        tick(); tick();                           // E3, E4
        check("single_mv_e4", m_valid, 0);
        tick();                                   // E5
        check("single_mv_e5", m_valid, 1);
        check("single_md_e5", m_data, 16'h0015);
        tick();
        check("single_hold_mv", m_valid, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("single_rel_mv", m_valid, 0);
        check("single_rel_busy", busy, 0);

        // Reset mid-WAIT
        s_valid = 1'b1; s_data = 8'h05;
        tick();
        s_data = 8'h06;
        tick();
        s_valid = 1'b0;
        check("rmw_go", fir_go, 1);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rmw_fir_go", fir_go, 0);
        check("rmw_m_valid", m_valid, 0);
        check("rmw_level", level, 0);
        check("rmw_m_data", m_data, 0);
        check("rmw_busy", busy, 0);
        tick();
        rst = 1'b1;
        m_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fir_go || m_valid) seen = 1;
        end
        m_ready = 1'b0;
        check("rmw_no_stale", seen, 0);

        // Burst with m_ready held high
        foreach (burst[i]) begin
            push_q.push_back(burst[i].din);
            exp_q.push_back(burst[i].res);
        end
        run(1'b0, 200);
        check("burst_saw_full", saw_full, 1);
        check("burst_go_cnt", go_cyc.size(), 5);
        check("burst_res_cnt", res_cyc.size(), 5);
        for (int i = 1; i < go_cyc.size(); i++)
            check("burst_go_gap", go_cyc[i] - go_cyc[i-1], 5);
        for (int i = 1; i < res_cyc.size(); i++)
            check("burst_res_gap", res_cyc[i] - res_cyc[i-1], 5);
        check("burst_idle", busy, 0);

        // Backpressure with 2 queued samples
        s_valid = 1'b1; s_data = 8'h0A;
        tick();
        s_data = 8'h0B;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 20 && !m_valid; i++) tick();
        check("bp_valid", m_valid, 1);
        ok_a = 1; ok_b = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_data !== 16'h001E || !m_valid) ok_a = 0;
            if (fir_go) ok_b = 0;
        end
        check("bp_held", ok_a, 1);
        check("bp_no_go", ok_b, 0 + 1);
        check("bp_level", level, 1);
        m_ready = 1'b1;
        tick();
        check("bp_go", fir_go, 1);
        check("bp_in", fir_in, 8'h0B);
        check("bp_mv", m_valid, 0);
        exp_q.push_back(16'h0021);
        run(1'b0, 50);

        // Full FIFO with an offer held during HOLD
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'(8'h10 + i);
            tick();
        end
        check("full_lvl", level, 4);
        s_data = 8'hEE;
        ok_a = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (level !== 3'd4 || s_ready) ok_a = 0;
        end
        check("full_blocked", ok_a, 1);
        check("full_mv", m_valid, 1);
        check("full_md", m_data, 16'h0030);
        m_ready = 1'b1;
        tick();                                   // pop edge
        check("full_pop_lvl", level, 3);
        check("full_pop_go", fir_go, 1);
        check("full_pop_in", fir_in, 8'h11);
        check("full_pop_rdy", s_ready, 1);
        tick();                                   // push of 8'hEE
        s_valid = 1'b0;
        check("full_push_lvl", level, 4);
        exp_q = '{16'h0033, 16'h0036, 16'h0039, 16'h003C, 16'h02CA};
        run(1'b0, 200);
        check("full_end_lvl", level, 0);
        check("full_end_busy", busy, 0);

        // Pointer wrap with random backpressure
        foreach (wrap[i]) begin
            push_q.push_back(wrap[i].din);
            exp_q.push_back(wrap[i].res);
        end
        run(1'b1, 2000);
        check("wrap_lvl", level, 0);
        check("wrap_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
